// File: rtl/tl_buffer_pkg.sv
// Shared TileLink channel payload types and the skid-buffer state encoding.
package tl_buffer_pkg;

  localparam int unsigned TL_AW   = 32;
  localparam int unsigned TL_DW   = 32;
  localparam int unsigned TL_SRCW = 8;
  localparam int unsigned TL_SNKW = 8;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [2:0]         param;
    logic [2:0]         size;
    logic [TL_SRCW-1:0] source;
    logic [TL_AW-1:0]   address;
    logic [TL_DW/8-1:0] mask;
    logic [TL_DW-1:0]   data;
    logic               corrupt;
  } tl_a_chan_t;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [2:0]         param;
    logic [2:0]         size;
    logic [TL_SRCW-1:0] source;
    logic [TL_AW-1:0]   address;
    logic [TL_DW/8-1:0] mask;
    logic [TL_DW-1:0]   data;
    logic               corrupt;
  } tl_b_chan_t;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [2:0]         param;
    logic [2:0]         size;
    logic [TL_SRCW-1:0] source;
    logic [TL_AW-1:0]   address;
    logic [TL_DW-1:0]   data;
    logic               corrupt;
  } tl_c_chan_t;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [1:0]         param;
    logic [2:0]         size;
    logic [TL_SRCW-1:0] source;
    logic [TL_SNKW-1:0] sink;
    logic               denied;
    logic [TL_DW-1:0]   data;
    logic               corrupt;
  } tl_d_chan_t;

  typedef struct packed {
    logic [TL_SNKW-1:0] sink;
  } tl_e_chan_t;

  // Encoding is {main_v, skid_v} so the handshake outputs are plain state bits.
  typedef enum logic [1:0] {
    SB_EMPTY = 2'b00,
    SB_ONE   = 2'b10,
    SB_TWO   = 2'b11
  } skid_state_e;

endpackage

// File: rtl/tl_bus.sv
// TileLink bus bundle: five valid/ready channels with struct payloads.
interface TL_BUS;
  import tl_buffer_pkg::*;

  logic       a_valid, a_ready;
  tl_a_chan_t a_bits;
  logic       b_valid, b_ready;
  tl_b_chan_t b_bits;
  logic       c_valid, c_ready;
  tl_c_chan_t c_bits;
  logic       d_valid, d_ready;
  tl_d_chan_t d_bits;
  logic       e_valid, e_ready;
  tl_e_chan_t e_bits;

  modport Master (
    output a_valid, a_bits, input  a_ready,
    input  b_valid, b_bits, output b_ready,
    output c_valid, c_bits, input  c_ready,
    input  d_valid, d_bits, output d_ready,
    output e_valid, e_bits, input  e_ready
  );

  modport Slave (
    input  a_valid, a_bits, output a_ready,
    output b_valid, b_bits, input  b_ready,
    input  c_valid, c_bits, output c_ready,
    output d_valid, d_bits, input  d_ready,
    input  e_valid, e_bits, output e_ready
  );
endinterface

// File: rtl/tl_buffer_skid_buf.sv
// Two-entry skid buffer: every output is a register; only in_ready sees rst_ni combinationally.
module tl_skid_buf
  import tl_buffer_pkg::*;
#(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_bits,
  output logic out_valid,
  input  logic out_ready,
  output T     out_bits
);

  skid_state_e r_state;
  T            r_main_q;
  T            r_skid_q;
  logic        w_acc_in;
  logic        w_acc_out;

  assign in_ready  = ~r_state[0] & rst_ni;
  assign out_valid = r_state[1];
  assign out_bits  = r_main_q;
  assign w_acc_in  = in_valid & in_ready;
  assign w_acc_out = out_valid & out_ready;

  // Payload registers load only on accept and are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= SB_EMPTY;
    end else begin
      unique case (r_state)
        SB_EMPTY: begin
          if (w_acc_in) begin
            r_state  <= SB_ONE;
            r_main_q <= in_bits;
          end
        end
        SB_ONE: begin
          if (w_acc_in && w_acc_out) begin
            r_main_q <= in_bits;
          end else if (w_acc_in) begin
            r_state  <= SB_TWO;
            r_skid_q <= in_bits;
          end else if (w_acc_out) begin
            r_state  <= SB_EMPTY;
          end
        end
        SB_TWO: begin
          if (w_acc_out) begin
            r_state  <= SB_ONE;
            r_main_q <= r_skid_q;
          end
        end
        default: r_state <= SB_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/tl_buffer.sv
// Registered TileLink slice: A/C/E flow slv->mst, B/D flow mst->slv, each optionally skid-buffered.
module tl_buffer
  import tl_buffer_pkg::*;
#(
  parameter bit BUF_A = 1'b1,
  parameter bit BUF_B = 1'b1,
  parameter bit BUF_C = 1'b1,
  parameter bit BUF_D = 1'b1,
  parameter bit BUF_E = 1'b1
) (
  input logic   clk_i,
  input logic   rst_ni,
  TL_BUS.Slave  slv,
  TL_BUS.Master mst
);

  if (BUF_A) begin : g_a
    tl_skid_buf #(.T(tl_a_chan_t)) u_buf (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid(slv.a_valid), .in_ready(slv.a_ready), .in_bits(slv.a_bits),
      .out_valid(mst.a_valid), .out_ready(mst.a_ready), .out_bits(mst.a_bits)
    );
  end else begin : g_a_wire
    assign mst.a_valid = slv.a_valid;
    assign mst.a_bits  = slv.a_bits;
    assign slv.a_ready = mst.a_ready;
  end

  if (BUF_B) begin : g_b
    tl_skid_buf #(.T(tl_b_chan_t)) u_buf (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid(mst.b_valid), .in_ready(mst.b_ready), .in_bits(mst.b_bits),
      .out_valid(slv.b_valid), .out_ready(slv.b_ready), .out_bits(slv.b_bits)
    );
  end else begin : g_b_wire
    assign slv.b_valid = mst.b_valid;
    assign slv.b_bits  = mst.b_bits;
    assign mst.b_ready = slv.b_ready;
  end

  if (BUF_C) begin : g_c
    tl_skid_buf #(.T(tl_c_chan_t)) u_buf (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid(slv.c_valid), .in_ready(slv.c_ready), .in_bits(slv.c_bits),
      .out_valid(mst.c_valid), .out_ready(mst.c_ready), .out_bits(mst.c_bits)
    );
  end else begin : g_c_wire
    assign mst.c_valid = slv.c_valid;
    assign mst.c_bits  = slv.c_bits;
    assign slv.c_ready = mst.c_ready;
  end

  if (BUF_D) begin : g_d
    tl_skid_buf #(.T(tl_d_chan_t)) u_buf (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid(mst.d_valid), .in_ready(mst.d_ready), .in_bits(mst.d_bits),
      .out_valid(slv.d_valid), .out_ready(slv.d_ready), .out_bits(slv.d_bits)
    );
  end else begin : g_d_wire
    assign slv.d_valid = mst.d_valid;
    assign slv.d_bits  = mst.d_bits;
    assign mst.d_ready = slv.d_ready;
  end

  if (BUF_E) begin : g_e
    tl_skid_buf #(.T(tl_e_chan_t)) u_buf (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid(slv.e_valid), .in_ready(slv.e_ready), .in_bits(slv.e_bits),
      .out_valid(mst.e_valid), .out_ready(mst.e_ready), .out_bits(mst.e_bits)
    );
  end else begin : g_e_wire
    assign mst.e_valid = slv.e_valid;
    assign mst.e_bits  = slv.e_bits;
    assign slv.e_ready = mst.e_ready;
  end

endmodule
